// File: rtl/tb_csr_pkg.sv
// rtl/tb_csr_pkg.sv - address map and register bit positions for tb_result_csr
package tb_csr_pkg;

    localparam int ADDR_CTRL    = 0;
    localparam int ADDR_STATUS  = 1;
    localparam int ADDR_VERSION = 2;
    localparam int ADDR_CAP_A   = 3;
    localparam int ADDR_CAP_B   = 4;
    localparam int ADDR_CAP_S   = 5;
    localparam int ADDR_CAP_CH  = 6;
    localparam int CTR_BASE     = 16;

    localparam int CTRL_RESET    = 0;
    localparam int CTRL_ENABLE   = 1;
    localparam int CTRL_FREEZE   = 2;
    localparam int CTRL_SNAPSHOT = 3;
    localparam int CTRL_CLEAR    = 4;

    localparam int ST_COUNT_W  = 8;
    localparam int ST_EMPTY    = 8;
    localparam int ST_FULL     = 9;
    localparam int ST_OVERFLOW = 10;

    localparam int CH_W = 5;

endpackage

// File: rtl/capture_fifo.sv
// rtl/capture_fifo.sv - synchronous first-word-fall-through FIFO for capture records
module capture_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tb_result_csr.sv
// rtl/tb_result_csr.sv - multi-channel result CSR block with counters, shadows and capture FIFO
module tb_result_csr
    import tb_csr_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int N_CH        = 4,
    parameter int CAP_DEPTH   = 8,
    parameter int ADDR_W      = 6,
    parameter int SYS_VERSION = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     slave_address,
    input  logic                  slave_read,
    input  logic                  slave_write,
    input  logic [WIDTH-1:0]      slave_writedata,
    output logic [WIDTH-1:0]      slave_readdata,
    output logic                  slave_readdatavalid,
    output logic                  ctrl_reset,
    output logic                  ctrl_enable,
    output logic                  ctrl_freeze,
    input  logic [N_CH-1:0]       i_data_vld,
    input  logic [N_CH-1:0]       i_event,
    input  logic [N_CH*WIDTH-1:0] i_cap_a,
    input  logic [N_CH*WIDTH-1:0] i_cap_b,
    input  logic [N_CH*WIDTH-1:0] i_cap_s
);

    localparam int REC_W = 3*WIDTH + CH_W;
    localparam int CNT_W = $clog2(CAP_DEPTH) + 1;

    logic [2:0]           ctrl;
    logic                 rd_en, wr_en, ctrl_wr;
    logic                 snapshot_cmd, clear_cmd;
    logic [WIDTH-1:0]     live_data [N_CH];
    logic [WIDTH-1:0]     live_evt  [N_CH];
    logic [WIDTH-1:0]     sh_data   [N_CH];
    logic [WIDTH-1:0]     sh_evt    [N_CH];
    logic [WIDTH-1:0]     cap_a, cap_b, cap_s;
    logic [CH_W-1:0]      cap_ch;
    logic                 push, pop, fifo_full, fifo_empty, overflow;
    logic [CNT_W-1:0]     fifo_count;
    logic [REC_W-1:0]     head;
    logic [ST_OVERFLOW:0] status;
    logic [WIDTH-1:0]     rd_mux;
    logic                 unused_wdata;

    // Simultaneous read and write strobes are treated as no access at all.
    assign rd_en        = slave_read && !slave_write;
    assign wr_en        = slave_write && !slave_read;
    assign ctrl_wr      = wr_en && (slave_address == ADDR_W'(ADDR_CTRL));
    assign snapshot_cmd = ctrl_wr && slave_writedata[CTRL_SNAPSHOT];
    assign clear_cmd    = ctrl_wr && slave_writedata[CTRL_CLEAR];
    assign unused_wdata = ^slave_writedata[WIDTH-1:CTRL_CLEAR+1];

    assign ctrl_reset  = ctrl[CTRL_RESET];
    assign ctrl_enable = ctrl[CTRL_ENABLE];
    assign ctrl_freeze = ctrl[CTRL_FREEZE];

    always_ff @(posedge clk) begin
        if (reset) ctrl <= '0;
        else if (ctrl_wr) ctrl <= slave_writedata[2:0];
    end

    // Descending scan so the lowest-index asserting channel wins.
    always_comb begin
        cap_ch = '0;
        cap_a  = '0;
        cap_b  = '0;
        cap_s  = '0;
        for (int k = N_CH-1; k >= 0; k--) begin
            if (i_event[k]) begin
                cap_ch = CH_W'(k);
                cap_a  = i_cap_a[k*WIDTH +: WIDTH];
                cap_b  = i_cap_b[k*WIDTH +: WIDTH];
                cap_s  = i_cap_s[k*WIDTH +: WIDTH];
            end
        end
    end

    assign push = (|i_event) && !ctrl[CTRL_FREEZE] && !clear_cmd;
    assign pop  = rd_en && (slave_address == ADDR_W'(ADDR_CAP_CH));

    capture_fifo #(
        .DATA_W (REC_W),
        .DEPTH  (CAP_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear_cmd),
        .push  (push),
        .pop   (pop),
        .wdata ({cap_a, cap_b, cap_s, cap_ch}),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset || clear_cmd) overflow <= 1'b0;
        else if (push && fifo_full && !pop) overflow <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || clear_cmd) begin
            for (int k = 0; k < N_CH; k++) begin
                live_data[k] <= '0;
                live_evt[k]  <= '0;
                sh_data[k]   <= '0;
                sh_evt[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (!ctrl[CTRL_FREEZE]) begin
                    if (i_data_vld[k] && live_data[k] != '1) live_data[k] <= live_data[k] + WIDTH'(1);
                    if (i_event[k] && live_evt[k] != '1)     live_evt[k]  <= live_evt[k] + WIDTH'(1);
                end
                if (snapshot_cmd) begin
                    sh_data[k] <= live_data[k];
                    sh_evt[k]  <= live_evt[k];
                end
            end
        end
    end

    always_comb begin
        status                   = '0;
        status[ST_COUNT_W-1:0]   = ST_COUNT_W'(fifo_count);
        status[ST_EMPTY]         = fifo_empty;
        status[ST_FULL]          = fifo_full;
        status[ST_OVERFLOW]      = overflow;
    end

    always_comb begin
        rd_mux = '0;
        case (slave_address)
            ADDR_W'(ADDR_CTRL):    rd_mux = WIDTH'(ctrl);
            ADDR_W'(ADDR_STATUS):  rd_mux = WIDTH'(status);
            ADDR_W'(ADDR_VERSION): rd_mux = WIDTH'(SYS_VERSION);
            ADDR_W'(ADDR_CAP_A):   rd_mux = head[REC_W-1 -: WIDTH];
            ADDR_W'(ADDR_CAP_B):   rd_mux = head[REC_W-1-WIDTH -: WIDTH];
            ADDR_W'(ADDR_CAP_S):   rd_mux = head[CH_W +: WIDTH];
            ADDR_W'(ADDR_CAP_CH):  rd_mux = WIDTH'(head[CH_W-1:0]);
            default: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (slave_address == ADDR_W'(CTR_BASE + 2*k))     rd_mux = sh_data[k];
                    if (slave_address == ADDR_W'(CTR_BASE + 2*k + 1)) rd_mux = sh_evt[k];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slave_readdata      <= '0;
            slave_readdatavalid <= 1'b0;
        end else begin
            slave_readdata      <= rd_en ? rd_mux : '0;
            slave_readdatavalid <= rd_en;
        end
    end

endmodule

// File: tb/tb_tb_result_csr.sv
// tb/tb_tb_result_csr.sv - scoreboard bench for tb_result_csr
module tb_tb_result_csr;

    typedef struct {
        logic [31:0] exp;
        string       nm;
        int          t;
    } sb_t;

    logic         clk = 1'b0;
    logic         reset;
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_fail = 0;
    sb_t          main_q[$];
    sb_t          sat_q[$];

    logic [5:0]   address;
    logic         read, write;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         rvalid;
    logic         c_reset, c_enable, c_freeze;
    logic [3:0]   data_vld, evt;
    logic [127:0] cap_a, cap_b, cap_s;

    logic [5:0]   s_address;
    logic         s_read, s_write;
    logic [7:0]   s_writedata;
    logic [7:0]   s_readdata;
    logic         s_rvalid;
    logic         s_unused_rst, s_unused_en, s_unused_frz;
    logic [3:0]   s_data_vld, s_evt;
    logic [31:0]  s_cap;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tb_result_csr u_dut (
        .clk                 (clk),
        .reset               (reset),
        .slave_address       (address),
        .slave_read          (read),
        .slave_write         (write),
        .slave_writedata     (writedata),
        .slave_readdata      (readdata),
        .slave_readdatavalid (rvalid),
        .ctrl_reset          (c_reset),
        .ctrl_enable         (c_enable),
        .ctrl_freeze         (c_freeze),
        .i_data_vld          (data_vld),
        .i_event             (evt),
        .i_cap_a             (cap_a),
        .i_cap_b             (cap_b),
        .i_cap_s             (cap_s)
    );

    tb_result_csr #(.WIDTH(8)) u_sat (
        .clk                 (clk),
        .reset               (reset),
        .slave_address       (s_address),
        .slave_read          (s_read),
        .slave_write         (s_write),
        .slave_writedata     (s_writedata),
        .slave_readdata      (s_readdata),
        .slave_readdatavalid (s_rvalid),
        .ctrl_reset          (s_unused_rst),
        .ctrl_enable         (s_unused_en),
        .ctrl_freeze         (s_unused_frz),
        .i_data_vld          (s_data_vld),
        .i_event             (s_evt),
        .i_cap_a             (s_cap),
        .i_cap_b             (s_cap),
        .i_cap_s             (s_cap)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_main
        sb_t e;
        if (rvalid === 1'b1) begin
            if (main_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL main_spurious_rvalid: got readdatavalid=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = main_q.pop_front();
                chk(e.nm, readdata, e.exp);
                chk({e.nm, "_latency"}, cyc, e.t + 1);
            end
        end
    end

    always @(negedge clk) begin : mon_sat
        sb_t e;
        if (s_rvalid === 1'b1) begin
            if (sat_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sat_spurious_rvalid: got readdatavalid=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = sat_q.pop_front();
                chk(e.nm, 32'(s_readdata), e.exp);
                chk({e.nm, "_latency"}, cyc, e.t + 1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input bit sat, input int a, input logic [31:0] exp, input string nm);
        sb_t e;
        e.exp = exp;
        e.nm  = nm;
        e.t   = cyc;
        if (sat) begin
            s_address = 6'(a);
            s_read    = 1'b1;
            sat_q.push_back(e);
        end else begin
            address = 6'(a);
            read    = 1'b1;
            main_q.push_back(e);
        end
        idle(1);
        read   = 1'b0;
        s_read = 1'b0;
    endtask

    task automatic wr(input bit sat, input int a, input logic [31:0] d);
        if (sat) begin
            s_address   = 6'(a);
            s_writedata = d[7:0];
            s_write     = 1'b1;
        end else begin
            address   = 6'(a);
            writedata = d;
            write     = 1'b1;
        end
        idle(1);
        write   = 1'b0;
        s_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        address = '0; read = 1'b0; write = 1'b0; writedata = '0;
        data_vld = '0; evt = '0; cap_a = '0; cap_b = '0; cap_s = '0;
        s_address = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
        s_data_vld = '0; s_evt = '0; s_cap = '0;
        idle(3);
        chk("reset_ctrl_bits", {29'b0, c_reset, c_enable, c_freeze}, 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        reset = 1'b0;

        rd(0, 2, 32'h8, "version");
        rd(0, 1, 32'h100, "status_reset");

        wr(0, 0, 32'h3);
        chk("ctrl_enable_on", 32'(c_enable), 32'h1);
        data_vld = 4'b0100;
        idle(5);
        data_vld = '0;
        wr(0, 0, 32'hB);
        rd(0, 20, 32'd5, "data_ctr2");
        rd(0, 16, 32'd0, "data_ctr0");
        rd(0, 21, 32'd0, "event_ctr2_pre");
        rd(0, 0, 32'h3, "ctrl_readback");
        chk("ctrl_enable_kept", 32'(c_enable), 32'h1);

        cap_a[32 +: 32] = 32'h11; cap_b[32 +: 32] = 32'h22; cap_s[32 +: 32] = 32'h34;
        cap_a[64 +: 32] = 32'h99; cap_b[64 +: 32] = 32'h98; cap_s[64 +: 32] = 32'h97;
        evt = 4'b0110;
        idle(1);
        evt = '0;
        rd(0, 1, 32'h1, "status_one");
        rd(0, 3, 32'h11, "cap_a");
        rd(0, 4, 32'h22, "cap_b");
        rd(0, 5, 32'h34, "cap_s");
        rd(0, 6, 32'h1, "cap_ch_pop");
        rd(0, 1, 32'h100, "status_after_pop");
        rd(0, 3, 32'h0, "cap_a_empty");
        wr(0, 0, 32'hB);
        rd(0, 19, 32'd1, "event_ctr1");
        rd(0, 21, 32'd1, "event_ctr2");
        rd(0, 20, 32'd5, "data_ctr2_held");

        for (int i = 0; i < 9; i++) begin
            cap_a[31:0] = 32'h100 + 32'(i);
            evt = 4'b0001;
            idle(1);
        end
        evt = '0;
        rd(0, 1, 32'h608, "status_full_ovf");
        rd(0, 3, 32'h100, "cap_a_oldest");
        cap_a[31:0] = 32'h1FF;
        evt = 4'b0001;
        rd(0, 6, 32'h0, "pop_with_push");
        evt = '0;
        rd(0, 1, 32'h608, "status_still_full");
        rd(0, 3, 32'h101, "cap_a_second");

        wr(0, 0, 32'h17);
        rd(0, 1, 32'h100, "status_cleared");
        rd(0, 20, 32'd0, "shadow_cleared");
        data_vld = 4'hF;
        for (int i = 0; i < 10; i++) begin
            evt = (i < 3) ? 4'hF : 4'h0;
            idle(1);
        end
        data_vld = '0;
        evt = '0;
        wr(0, 0, 32'hF);
        chk("ctrl_freeze_on", 32'(c_freeze), 32'h1);
        rd(0, 16, 32'd0, "frz_data0");
        rd(0, 17, 32'd0, "frz_evt0");
        rd(0, 22, 32'd0, "frz_data3");
        rd(0, 23, 32'd0, "frz_evt3");
        rd(0, 1, 32'h100, "frz_status");

        wr(0, 0, 32'h3);
        data_vld = 4'b0001;
        idle(3);
        data_vld = '0;
        evt = 4'b0001;
        wr(0, 0, 32'h1B);
        evt = '0;
        rd(0, 16, 32'd0, "clear_beats_snapshot");
        rd(0, 1, 32'h100, "clear_drops_event");
        wr(0, 0, 32'hB);
        rd(0, 16, 32'd0, "live_data_cleared");
        rd(0, 17, 32'd0, "live_evt_cleared");

        cap_a[96 +: 32] = 32'hAB;
        evt = 4'b1000;
        idle(1);
        evt = '0;
        address = 6'd0; writedata = 32'h14; read = 1'b1; write = 1'b1;
        idle(1);
        address = 6'd6;
        idle(1);
        read = 1'b0; write = 1'b0;
        rd(0, 1, 32'h1, "collision_no_pop");
        chk("collision_no_write", 32'(c_freeze), 32'h0);
        rd(0, 6, 32'h3, "cap_ch3");

        address = 6'd2; read = 1'b1; reset = 1'b1;
        idle(1);
        read = 1'b0;
        chk("reset_mid_read_rvalid", 32'(rvalid), 32'h0);
        idle(1);
        reset = 1'b0;
        chk("reset_ctrl_enable", 32'(c_enable), 32'h0);
        rd(0, 1, 32'h100, "status_after_reset");

        s_data_vld = 4'b0001;
        idle(300);
        s_data_vld = '0;
        wr(1, 0, 32'h08);
        rd(1, 16, 32'hFF, "sat_data0");
        rd(1, 18, 32'h0, "sat_data1");
        wr(1, 0, 32'h10);
        rd(1, 16, 32'h0, "sat_shadow_cleared");
        wr(1, 0, 32'h08);
        rd(1, 16, 32'h0, "sat_live_cleared");

        idle(3);
        n_cmp++;
        if (main_q.size() != 0 || sat_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_responses: got %0d outstanding expected 0", main_q.size() + sat_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
